weight_buffer_loader: RTL and testbench



---
 rtl/weight_loader_pkg.sv | 37 +++
 rtl/weight_buffer_loader_if.sv | 48 ++++
 rtl/weight_buffer_loader_addr_gen.sv | 65 ++++++
 rtl/weight_buffer_loader.sv | 172 +++++++++++++++++
 tb/tb_weight_buffer_loader.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_loader_pkg.sv
// Shared types and elaboration helpers for the weight buffer loader.
// Holds the FSM state enum, clog2, and lane/group derivation.
package weight_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } wl_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Counter width that stays legal when only one value exists.
  function automatic int cnt_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int lanes_of(
    input int ddr_w,
    input int lane_w
  );
    return ddr_w / lane_w;
  endfunction

  function automatic int groups_of(
    input int buf_num,
    input int lanes
  );
    return buf_num / lanes;
  endfunction

endpackage

// File: rtl/weight_buffer_loader_if.sv
// DDR request, DDR read FIFO and weight-buffer write bus bundle.
// master = loader side; slave = DDR engine / FIFO / buffer side.
interface weight_buffer_loader_if #(
  parameter int DDR_ADDR_LEN = 32,
  parameter int DDR_DATA_LEN = 256,
  parameter int ADDR_LEN     = 16,
  parameter int SINGLE_LEN   = 24,
  parameter int BUFFER_NUM   = 16
);

  logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out;
  logic [SINGLE_LEN-1:0]   ddr_len;
  logic                    ddr_conf;
  logic                    ddr_fifo_empty;
  logic                    ddr_fifo_req;
  logic [DDR_DATA_LEN-1:0] ddr_fifo_data;
  logic [ADDR_LEN-1:0]     wb_addr;
  logic [DDR_DATA_LEN-1:0] wb_data;
  logic [BUFFER_NUM-1:0]   wb_wea;
  logic                    wb_bank;

  modport master (
    output ddr_st_addr_out,
    output ddr_len,
    output ddr_conf,
    output ddr_fifo_req,
    output wb_addr,
    output wb_data,
    output wb_wea,
    output wb_bank,
    input  ddr_fifo_empty,
    input  ddr_fifo_data
  );

  modport slave (
    input  ddr_st_addr_out,
    input  ddr_len,
    input  ddr_conf,
    input  ddr_fifo_req,
    input  wb_addr,
    input  wb_data,
    input  wb_wea,
    input  wb_bank,
    output ddr_fifo_empty,
    output ddr_fifo_data
  );

endinterface

// File: rtl/weight_buffer_loader_addr_gen.sv
// wl_addr_gen: tap/weight/group/offset counters for the loader.
// Ports: clear/step control, latched config in; addr, grp, last out.
module wl_addr_gen
  import weight_loader_pkg::*;
#(
  parameter int TAP_W      = 4,
  parameter int SINGLE_LEN = 24,
  parameter int ADDR_LEN   = 16,
  parameter int GROUPS     = 4,
  parameter int GRP_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  step,
  input  logic [TAP_W-1:0]      taps,
  input  logic [SINGLE_LEN-1:0] weight_num,
  input  logic [ADDR_LEN-1:0]   base,
  output logic [ADDR_LEN-1:0]   addr,
  output logic [GRP_W-1:0]      grp,
  output logic                  last
);

  logic [TAP_W-1:0]      tap_q;
  logic [SINGLE_LEN-1:0] w_q;
  logic [GRP_W-1:0]      grp_q;
  logic [ADDR_LEN-1:0]   off_q;
  logic                  tap_end;
  logic                  w_end;
  logic                  g_end;

  assign tap_end = (tap_q == taps - TAP_W'(1));
  assign w_end   = (w_q == weight_num - SINGLE_LEN'(1));
  assign g_end   = (grp_q == GRP_W'(GROUPS - 1));

  // Offset walks w*taps+t by increment, so no multiplier is needed.
  assign addr = base + off_q;
  assign grp  = grp_q;
  assign last = tap_end && w_end && g_end;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      tap_q <= '0;
      w_q   <= '0;
      grp_q <= '0;
      off_q <= '0;
    end else if (step) begin
      if (!tap_end) begin
        tap_q <= tap_q + TAP_W'(1);
        off_q <= off_q + ADDR_LEN'(1);
      end else begin
        tap_q <= '0;
        if (!w_end) begin
          w_q   <= w_q + SINGLE_LEN'(1);
          off_q <= off_q + ADDR_LEN'(1);
        end else begin
          w_q   <= '0;
          off_q <= '0;
          grp_q <= g_end ? '0 : grp_q + GRP_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/weight_buffer_loader.sv
// Streams one layer's weights from the DDR FIFO into the banked buffer.
// Ports: clk/rst_n, conf+cfg_*, abort, idle/done/cfg_err, bus (master).
module weight_buffer_loader
  import weight_loader_pkg::*;
#(
  parameter int DDR_ADDR_LEN = 32,
  parameter int DDR_DATA_LEN = 256,
  parameter int DATA_LEN     = 64,
  parameter int ADDR_LEN     = 16,
  parameter int SINGLE_LEN   = 24,
  parameter int BUFFER_NUM   = 16,
  parameter int TAPS_MAX     = 15,
  localparam int TAP_W       = clog2(TAPS_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    conf,
  input  logic [SINGLE_LEN-1:0]   cfg_weight_num,
  input  logic [TAP_W-1:0]        cfg_taps,
  input  logic [DDR_ADDR_LEN-1:0] cfg_ddr_addr,
  input  logic [ADDR_LEN-1:0]     cfg_wb_addr,
  input  logic                    cfg_bank,
  input  logic                    abort,
  output logic                    idle,
  output logic                    done,
  output logic                    cfg_err,
  weight_buffer_loader_if.master  bus
);

  localparam int LANES  = lanes_of(DDR_DATA_LEN, DATA_LEN);
  localparam int GROUPS = groups_of(BUFFER_NUM, LANES);
  localparam int GRP_W  = cnt_w(GROUPS);
  localparam int BEAT_B = DDR_DATA_LEN / 8;

  if (DDR_DATA_LEN % DATA_LEN != 0) begin : g_lane_chk
    $error("DDR_DATA_LEN must be a multiple of DATA_LEN");
  end
  if (BUFFER_NUM % LANES != 0) begin : g_grp_chk
    $error("BUFFER_NUM must be a multiple of LANES");
  end

  wl_state_e state_q;
  wl_state_e state_d;

  logic                  legal;
  logic                  accept;
  logic                  bad;
  logic                  done_d;
  logic                  consume;
  logic                  wr_en;
  logic                  clear;
  logic                  last;
  logic [GRP_W-1:0]      grp;
  logic [ADDR_LEN-1:0]   addr;
  logic [BUFFER_NUM-1:0] mask;
  logic [SINGLE_LEN-1:0] len_d;

  logic [TAP_W-1:0]      taps_q;
  logic [SINGLE_LEN-1:0] wn_q;
  logic [ADDR_LEN-1:0]   base_q;
  logic                  bank_q;

  assign legal = (cfg_weight_num != '0)
              && (cfg_taps != '0)
              && (cfg_taps <= TAP_W'(TAPS_MAX));

  assign consume = (state_q == ST_LOAD) && !bus.ddr_fifo_empty;
  assign bus.ddr_fifo_req = consume;
  assign idle = (state_q == ST_IDLE);

  // A beat popped in the abort cycle is discarded, not written.
  assign wr_en = consume && !abort;
  assign clear = accept || (abort && !idle);

  // Byte length wraps to SINGLE_LEN like the original controller.
  assign len_d = SINGLE_LEN'(GROUPS)
               * cfg_weight_num
               * SINGLE_LEN'(cfg_taps)
               * SINGLE_LEN'(BEAT_B);

  assign mask = BUFFER_NUM'({LANES{1'b1}})
             << (int'(grp) * LANES);

  wl_addr_gen #(
    .TAP_W      (TAP_W),
    .SINGLE_LEN (SINGLE_LEN),
    .ADDR_LEN   (ADDR_LEN),
    .GROUPS     (GROUPS),
    .GRP_W      (GRP_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .step       (consume),
    .taps       (taps_q),
    .weight_num (wn_q),
    .base       (base_q),
    .addr       (addr),
    .grp        (grp),
    .last       (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    bad     = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (conf) begin
          if (legal) begin
            accept  = 1'b1;
            state_d = ST_LOAD;
          end else begin
            bad = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (abort)              state_d = ST_IDLE;
        else if (consume && last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        done_d  = !abort;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taps_q              <= '0;
      wn_q                <= '0;
      base_q              <= '0;
      bank_q              <= 1'b0;
      bus.ddr_st_addr_out <= '0;
      bus.ddr_len         <= '0;
      bus.ddr_conf        <= 1'b0;
      cfg_err             <= 1'b0;
      done                <= 1'b0;
      bus.wb_addr         <= '0;
      bus.wb_data         <= '0;
      bus.wb_wea          <= '0;
      bus.wb_bank         <= 1'b0;
    end else begin
      bus.ddr_conf <= accept;
      cfg_err      <= bad;
      done         <= done_d;
      if (accept) begin
        taps_q              <= cfg_taps;
        wn_q                <= cfg_weight_num;
        base_q              <= cfg_wb_addr;
        bank_q              <= cfg_bank;
        bus.ddr_st_addr_out <= cfg_ddr_addr;
        bus.ddr_len         <= len_d;
      end
      bus.wb_wea <= wr_en ? mask : '0;
      if (wr_en) begin
        bus.wb_addr <= addr;
        bus.wb_data <= bus.ddr_fifo_data;
        bus.wb_bank <= bank_q;
      end
    end
  end

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Directed self-checking bench for weight_buffer_loader.
// Drives a model FIFO, records writes/pulses, checks against hand values.
module tb_weight_buffer_loader;

  localparam int GROUPS = 4;
  localparam int TAP_W  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        conf;
  logic [23:0] cfg_weight_num;
  logic [TAP_W-1:0] cfg_taps;
  logic [31:0] cfg_ddr_addr;
  logic [15:0] cfg_wb_addr;
  logic        cfg_bank;
  logic        abort;
  logic        idle;
  logic        done;
  logic        cfg_err;

  logic        alt = 1'b0;
  int          cyc = 0;
  int          c0 = 0;
  logic [31:0] pop_cnt = '0;
  logic [31:0] pop0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int            cyc;
    logic [15:0]   addr;
    logic [255:0]  data;
    logic [15:0]   wea;
    logic          bank;
  } wr_t;

  wr_t wq[$];
  int  done_q[$];
  int  err_q[$];
  int  dconf_q[$];

  always #5 clk = ~clk;

  weight_buffer_loader_if #(
    .DDR_ADDR_LEN (32),
    .DDR_DATA_LEN (256),
    .ADDR_LEN     (16),
    .SINGLE_LEN   (24),
    .BUFFER_NUM   (16)
  ) bus ();

  weight_buffer_loader #(
    .DDR_ADDR_LEN (32),
    .DDR_DATA_LEN (256),
    .DATA_LEN     (64),
    .ADDR_LEN     (16),
    .SINGLE_LEN   (24),
    .BUFFER_NUM   (16),
    .TAPS_MAX     (15)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .conf           (conf),
    .cfg_weight_num (cfg_weight_num),
    .cfg_taps       (cfg_taps),
    .cfg_ddr_addr   (cfg_ddr_addr),
    .cfg_wb_addr    (cfg_wb_addr),
    .cfg_bank       (cfg_bank),
    .abort          (abort),
    .idle           (idle),
    .done           (done),
    .cfg_err        (cfg_err),
    .bus            (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.ddr_fifo_req) pop_cnt <= pop_cnt + 1;

  assign bus.ddr_fifo_data  = {8{pop_cnt}};
  assign bus.ddr_fifo_empty = alt && (((cyc - c0) & 1) == 1);

  always @(negedge clk) begin : mon
    wr_t r;
    if (bus.wb_wea != '0) begin
      r.cyc  = cyc - c0;
      r.addr = bus.wb_addr;
      r.data = bus.wb_data;
      r.wea  = bus.wb_wea;
      r.bank = bus.wb_bank;
      wq.push_back(r);
    end
    if (done)         done_q.push_back(cyc - c0);
    if (cfg_err)      err_q.push_back(cyc - c0);
    if (bus.ddr_conf) dconf_q.push_back(cyc - c0);
  end

  task automatic chk(
    input string        tag,
    input logic [255:0] got,
    input logic [255:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Presents conf during cycle 0; returns at mid-cycle 1.
  task automatic start(
    input int          wn,
    input int          tp,
    input logic [15:0] wb,
    input logic        bk,
    input logic        ab
  );
    @(negedge clk);
    wq.delete();
    done_q.delete();
    err_q.delete();
    dconf_q.delete();
    cfg_weight_num = 24'(wn);
    cfg_taps       = TAP_W'(tp);
    cfg_wb_addr    = wb;
    cfg_bank       = bk;
    cfg_ddr_addr   = 32'h1000_0000 + 32'(wn * 256 + tp);
    conf  = 1'b1;
    abort = ab;
    c0    = cyc;
    pop0  = pop_cnt;
    @(negedge clk);
    conf  = 1'b0;
    abort = 1'b0;
  endtask

  task automatic expect_load(
    input int          wn,
    input int          tp,
    input logic [15:0] wb,
    input logic        bk
  );
    int n;
    int k;
    logic [15:0] ea;
    n = GROUPS * wn * tp;
    chk("ddr_conf_c1", bus.ddr_conf, 1);
    chk("idle_c1", idle, 0);
    chk("ddr_addr", bus.ddr_st_addr_out, cfg_ddr_addr);
    chk("ddr_len", bus.ddr_len, n * 32);
    for (int i = 0; i < 400 && done_q.size() == 0; i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    chk("n_done", done_q.size(), 1);
    if (done_q.size() > 0)
      chk("done_cyc", done_q[0], alt ? 2 * n + 2 : n + 2);
    chk("n_conf", dconf_q.size(), 1);
    chk("n_writes", wq.size(), n);
    chk("idle_end", idle, 1);
    k = 0;
    for (int g = 0; g < GROUPS; g++)
      for (int w = 0; w < wn; w++)
        for (int t = 0; t < tp; t++) begin
          if (k < wq.size()) begin
            ea = wb + 16'(w * tp + t);
            chk("wr_addr", wq[k].addr, ea);
            chk("wr_wea", wq[k].wea, 16'hF << (4 * g));
            chk("wr_data", wq[k].data, {8{32'(pop0 + k)}});
            chk("wr_bank", wq[k].bank, bk);
            chk("wr_cyc", wq[k].cyc, alt ? 2 * k + 3 : k + 2);
          end
          k++;
        end
  endtask

  task automatic expect_reject();
    chk("err_c1", cfg_err, 1);
    chk("conf_c1_off", bus.ddr_conf, 0);
    chk("idle_rej", idle, 1);
    chk("req_rej", bus.ddr_fifo_req, 0);
    repeat (4) @(negedge clk);
    chk("n_err", err_q.size(), 1);
    chk("n_conf_rej", dconf_q.size(), 0);
    chk("n_wr_rej", wq.size(), 0);
    chk("idle_rej2", idle, 1);
  endtask

  initial begin
    rst_n          = 1'b0;
    conf           = 1'b0;
    abort          = 1'b0;
    cfg_weight_num = '0;
    cfg_taps       = '0;
    cfg_ddr_addr   = '0;
    cfg_wb_addr    = '0;
    cfg_bank       = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_idle", idle, 1);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_dconf", bus.ddr_conf, 0);
    chk("rst_req", bus.ddr_fifo_req, 0);
    chk("rst_wea", bus.wb_wea, 0);
    chk("rst_len", bus.ddr_len, 0);
    chk("rst_addr", bus.ddr_st_addr_out, 0);
    chk("rst_wbaddr", bus.wb_addr, 0);
    rst_n = 1'b1;

    // full-rate, 2 weights x 9 taps, bank 1
    start(2, 9, 16'h0010, 1'b1, 1'b0);
    expect_load(2, 9, 16'h0010, 1'b1);

    // single beat per group; abort alongside conf is ignored
    start(1, 1, 16'h0010, 1'b0, 1'b1);
    expect_load(1, 1, 16'h0010, 1'b0);

    // FIFO empty on alternate cycles
    alt = 1'b1;
    start(2, 9, 16'h0010, 1'b1, 1'b0);
    expect_load(2, 9, 16'h0010, 1'b1);
    alt = 1'b0;

    // illegal configs
    start(2, 0, 16'h0010, 1'b0, 1'b0);
    expect_reject();
    start(0, 3, 16'h0010, 1'b0, 1'b0);
    expect_reject();

    // abort once 50 writes have been scheduled
    start(2, 9, 16'h0010, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_idle", idle, 1);
    chk("ab_req", bus.ddr_fifo_req, 0);
    chk("ab_wea", bus.wb_wea, 0);
    repeat (80) @(negedge clk);
    chk("ab_n_wr", wq.size(), 50);
    if (wq.size() > 0)
      chk("ab_last_cyc", wq[wq.size()-1].cyc, 51);
    chk("ab_n_done", done_q.size(), 0);

    // normal load after abort
    start(1, 1, 16'h0010, 1'b1, 1'b0);
    expect_load(1, 1, 16'h0010, 1'b1);

    // buffer address wrap
    start(1, 3, 16'hFFFE, 1'b0, 1'b0);
    expect_load(1, 3, 16'hFFFE, 1'b0);

    // reset in the middle of a load
    start(2, 9, 16'h0010, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_idle", idle, 1);
    chk("mr_wea", bus.wb_wea, 0);
    chk("mr_len", bus.ddr_len, 0);
    chk("mr_req", bus.ddr_fifo_req, 0);
    repeat (80) @(negedge clk);
    chk("mr_n_done", done_q.size(), 0);
    chk("mr_idle2", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
